// File: rtl/dac_slot_scheduler.sv
// Two-slot frame scheduler for the shared stereo DAC: buffers one sample per channel, strobes A then B each frame.
// Define SCHED_MUTE_EN to issue midscale instead of repeating the last sample when a channel's buffer is empty.
module dac_slot_scheduler #(
  parameter int CLK_DIV  = 1042,
  parameter int SLOT_GAP = 100,
  parameter int SAMPLE_W = 12
) (
  input  logic                inClk,
  input  logic                inResetN,
  input  logic [SAMPLE_W-1:0] inSampleA,
  input  logic                inValidA,
  output logic                outReadyA,
  input  logic [SAMPLE_W-1:0] inSampleB,
  input  logic                inValidB,
  output logic                outReadyB,
  output logic [SAMPLE_W-1:0] outSample,
  output logic                outChannel,
  output logic                outSampleReady,
  output logic                outFrameTick,
  output logic [1:0]          outUnderrun,
  input  logic                inClearFlags
);

  // state   | meaning
  // WAIT_A  | waiting for frame counter == 0
  // ISSUE_A | A strobe on the outputs this cycle
  // WAIT_B  | waiting for frame counter == SLOT_GAP
  // ISSUE_B | B strobe on the outputs this cycle

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]       CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]       GAP_CNT  = CW'(SLOT_GAP);
  localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  generate
    if (SLOT_GAP < 1 || SLOT_GAP > CLK_DIV - 1) begin : gBadGap
      $error("dac_slot_scheduler: SLOT_GAP must be in 1..CLK_DIV-1");
    end
  endgenerate

  typedef enum logic [1:0] {WAIT_A, ISSUE_A, WAIT_B, ISSUE_B} state_t;

  state_t              state, stateNext;
  logic [CW-1:0]       frameCnt;
  logic                issueA, issueB;
  logic [SAMPLE_W-1:0] bufA, bufB, lastA, lastB, fillA, fillB;
  logic                fullA, fullB, armedA, armedB;
  logic                consumeA, consumeB;
  logic                underSetA, underSetB;

  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN)                 frameCnt <= '0;
    else if (frameCnt == CNT_LAST) frameCnt <= '0;
    else                           frameCnt <= frameCnt + 1'b1;
  end

  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) state <= WAIT_A;
    else           state <= stateNext;
  end

  // Issue decisions are made on the edge into ISSUE_x so the strobe lines up with that state.
  // ISSUE states also watch their successor's compare so the extreme SLOT_GAP values never miss a slot.
  always_comb begin
    stateNext = state;
    issueA    = 1'b0;
    issueB    = 1'b0;
    case (state)
      WAIT_A: if (frameCnt == '0) begin
        stateNext = ISSUE_A;
        issueA    = 1'b1;
      end
      ISSUE_A: if (frameCnt == GAP_CNT) begin
        stateNext = ISSUE_B;
        issueB    = 1'b1;
      end else begin
        stateNext = WAIT_B;
      end
      WAIT_B: if (frameCnt == GAP_CNT) begin
        stateNext = ISSUE_B;
        issueB    = 1'b1;
      end
      ISSUE_B: if (frameCnt == '0) begin
        stateNext = ISSUE_A;
        issueA    = 1'b1;
      end else begin
        stateNext = WAIT_A;
      end
      default: stateNext = WAIT_A;
    endcase
  end

`ifdef SCHED_MUTE_EN
  assign fillA = MIDSCALE;
  assign fillB = MIDSCALE;
`else
  assign fillA = lastA;
  assign fillB = lastB;
`endif

  assign outReadyA = ~fullA;
  assign outReadyB = ~fullB;
  assign underSetA = issueA & ~fullA & armedA;
  assign underSetB = issueB & ~fullB & armedB;

  // The buffer is released one cycle after the strobe, so ready never overlaps the issuing edge.
  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      fullA  <= 1'b0;
      fullB  <= 1'b0;
      armedA <= 1'b0;
      armedB <= 1'b0;
      bufA   <= '0;
      bufB   <= '0;
    end else begin
      if (consumeA) begin
        fullA <= 1'b0;
      end else if (inValidA && !fullA) begin
        bufA   <= inSampleA;
        fullA  <= 1'b1;
        armedA <= 1'b1;
      end
      if (consumeB) begin
        fullB <= 1'b0;
      end else if (inValidB && !fullB) begin
        bufB   <= inSampleB;
        fullB  <= 1'b1;
        armedB <= 1'b1;
      end
    end
  end

  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      outSample      <= MIDSCALE;
      outChannel     <= 1'b0;
      outSampleReady <= 1'b0;
      outFrameTick   <= 1'b0;
      lastA          <= MIDSCALE;
      lastB          <= MIDSCALE;
      consumeA       <= 1'b0;
      consumeB       <= 1'b0;
    end else begin
      outSampleReady <= issueA | issueB;
      outFrameTick   <= issueA;
      consumeA       <= issueA & fullA;
      consumeB       <= issueB & fullB;
      if (issueA) begin
        outChannel <= 1'b0;
        if (fullA) begin
          outSample <= bufA;
          lastA     <= bufA;
        end else begin
          outSample <= fillA;
        end
      end else if (issueB) begin
        outChannel <= 1'b1;
        if (fullB) begin
          outSample <= bufB;
          lastB     <= bufB;
        end else begin
          outSample <= fillB;
        end
      end
    end
  end

  // A fresh underrun outranks a clear arriving on the same edge.
  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      outUnderrun <= 2'b00;
    end else begin
      outUnderrun[0] <= underSetA | (outUnderrun[0] & ~inClearFlags);
      outUnderrun[1] <= underSetB | (outUnderrun[1] & ~inClearFlags);
    end
  end

endmodule

// File: tb/tb_dac_slot_scheduler.sv
// Directed bench for dac_slot_scheduler with CLK_DIV=16, SLOT_GAP=6.
// Cycle n is the state seen #1 after the n-th rising edge following reset release.
module tb_dac_slot_scheduler;

  logic        inClk = 1'b0;
  logic        inResetN;
  logic [11:0] inSampleA, inSampleB;
  logic        inValidA, inValidB;
  logic        outReadyA, outReadyB;
  logic [11:0] outSample;
  logic        outChannel, outSampleReady, outFrameTick;
  logic [1:0]  outUnderrun;
  logic        inClearFlags;

  int cyc = 0;
  int nCompared = 0;
  int nMismatched = 0;

`ifdef SCHED_MUTE_EN
  localparam logic [11:0] REPEAT_A1 = 12'h800;
  localparam logic [11:0] REPEAT_A2 = 12'h800;
`else
  localparam logic [11:0] REPEAT_A1 = 12'h456;
  localparam logic [11:0] REPEAT_A2 = 12'h321;
`endif

  dac_slot_scheduler #(.CLK_DIV(16), .SLOT_GAP(6), .SAMPLE_W(12)) dut (
    .inClk(inClk), .inResetN(inResetN),
    .inSampleA(inSampleA), .inValidA(inValidA), .outReadyA(outReadyA),
    .inSampleB(inSampleB), .inValidB(inValidB), .outReadyB(outReadyB),
    .outSample(outSample), .outChannel(outChannel), .outSampleReady(outSampleReady),
    .outFrameTick(outFrameTick), .outUnderrun(outUnderrun), .inClearFlags(inClearFlags)
  );

  always #5 inClk = ~inClk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge inClk);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int n);
    while (cyc < n) tick();
  endtask

  task automatic waitStrobe(input string tag, input int expCyc, input logic [11:0] expSample,
                            input logic expCh);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!outSampleReady && n < 40);
    checkVal({tag, "_cyc"}, cyc, expCyc);
    checkVal({tag, "_smp"}, outSample, expSample);
    checkVal({tag, "_ch"}, outChannel, expCh);
    checkVal({tag, "_tick"}, outFrameTick, !expCh);
  endtask

  task automatic push(input logic chB, input logic [11:0] smp);
    if (chB) begin inSampleB = smp; inValidB = 1'b1; end
    else     begin inSampleA = smp; inValidA = 1'b1; end
    tick();
    if (chB) inValidB = 1'b0;
    else     inValidA = 1'b0;
  endtask

  initial begin
    int strobesInReset;
    inResetN = 1'b0; inSampleA = '0; inSampleB = '0;
    inValidA = 1'b0; inValidB = 1'b0; inClearFlags = 1'b0;
    repeat (3) @(posedge inClk);
    #1;
    checkVal("rst_sample", outSample, 12'h800);
    checkVal("rst_strobe", outSampleReady, 1'b0);
    checkVal("rst_ready", {outReadyB, outReadyA}, 2'b11);
    checkVal("rst_under", outUnderrun, 2'b00);
    inResetN = 1'b1;
    cyc = 0;

    // idle frame: midscale in both slots, not armed so no underrun
    waitStrobe("idleA", 1, 12'h800, 1'b0);
    tick();
    checkVal("strobe_one_cycle", outSampleReady, 1'b0);
    waitStrobe("idleB", 7, 12'h800, 1'b1);
    checkVal("idle_under", outUnderrun, 2'b00);

    // load both channels, then hold a second A sample against a full buffer
    runTo(8);
    inSampleA = 12'h123; inValidA = 1'b1;
    inSampleB = 12'hABC; inValidB = 1'b1;
    tick();
    inValidB = 1'b0;
    inSampleA = 12'h456;
    checkVal("full_ready", {outReadyB, outReadyA}, 2'b00);
    waitStrobe("feedA", 17, 12'h123, 1'b0);
    checkVal("readyA_at_strobe", outReadyA, 1'b0);
    tick();
    checkVal("readyA_after", outReadyA, 1'b1);
    tick();
    checkVal("heldA_accepted", outReadyA, 1'b0);
    inValidA = 1'b0;
    waitStrobe("feedB", 23, 12'hABC, 1'b1);
    tick();
    checkVal("readyB_after", outReadyB, 1'b1);
    push(1'b1, 12'h0BB);
    waitStrobe("nextA", 33, 12'h456, 1'b0);
    waitStrobe("nextB", 39, 12'h0BB, 1'b1);
    checkVal("fed_under", outUnderrun, 2'b00);

    // A skipped this frame
    runTo(40);
    push(1'b1, 12'h0CC);
    waitStrobe("underA", 49, REPEAT_A1, 1'b0);
    checkVal("under_set", outUnderrun, 2'b01);
    inClearFlags = 1'b1;
    tick();
    inClearFlags = 1'b0;
    checkVal("under_clear", outUnderrun, 2'b00);
    waitStrobe("feedB2", 55, 12'h0CC, 1'b1);
    tick();
    push(1'b1, 12'h0DD);

    // clear coincident with a new underrun
    runTo(64);
    inClearFlags = 1'b1;
    waitStrobe("underA2", 65, REPEAT_A1, 1'b0);
    inClearFlags = 1'b0;
    checkVal("set_wins", outUnderrun, 2'b01);
    push(1'b0, 12'h777);
    waitStrobe("feedB3", 71, 12'h0DD, 1'b1);
    tick();
    push(1'b1, 12'h0EE);
    runTo(75);
    checkVal("both_full", {outReadyB, outReadyA}, 2'b00);

    // reset mid-frame with both buffers loaded
    inResetN = 1'b0;
    #1;
    checkVal("mid_rst_sample", outSample, 12'h800);
    checkVal("mid_rst_ready", {outReadyB, outReadyA}, 2'b11);
    checkVal("mid_rst_under", outUnderrun, 2'b00);
    checkVal("mid_rst_strobe", outSampleReady, 1'b0);
    strobesInReset = 0;
    repeat (20) begin
      tick();
      if (outSampleReady) strobesInReset++;
    end
    checkVal("no_strobe_in_rst", strobesInReset, 0);
    inResetN = 1'b1;
    cyc = 0;
    waitStrobe("postRstA", 1, 12'h800, 1'b0);
    checkVal("postRst_ready", {outReadyB, outReadyA}, 2'b11);
    tick();
    push(1'b0, 12'h321);
    waitStrobe("postRstB", 7, 12'h800, 1'b1);
    checkVal("postRst_under", outUnderrun, 2'b00);
    waitStrobe("feed321", 17, 12'h321, 1'b0);
    waitStrobe("emptyB", 23, 12'h800, 1'b1);
    checkVal("unarmedB_under", outUnderrun, 2'b00);
    waitStrobe("underA3", 33, REPEAT_A2, 1'b0);
    checkVal("under_set2", outUnderrun, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
